// File: rtl/gcd_lcm_engine.sv
// Iterative GCD/LCM engine: subtractive GCD, restoring divide A/GCD, single-cycle multiply by B.
// Optional macro GCD_LCM_CYC_CNT_EN adds cyc_cnt_out reporting the latency of each result.
module gcd_lcm_engine #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   a_in,
  input  logic [DATA_W-1:0]   b_in,
  input  logic                mode_in,
  input  logic [TAG_W-1:0]    tag_in,
  input  logic                vld_in,
  output logic                rdy_in,
  output logic [DATA_W-1:0]   gcd_out,
  output logic [2*DATA_W-1:0] lcm_out,
  output logic [TAG_W-1:0]    tag_out,
  output logic                vld_out,
  input  logic                rdy_out
`ifdef GCD_LCM_CYC_CNT_EN
  ,
  output logic [CNT_W-1:0]    cyc_cnt_out
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits for ready, and the result payload is frozen while valid && !ready.

  typedef enum logic [2:0] {S_IDLE, S_GCD, S_DIV, S_MUL, S_DONE} state_t;
  localparam int DC_W = $clog2(DATA_W + 1);

  state_t              state_q, state_d;
  logic                rdy_q, rdy_d;
  logic                vld_q, vld_d;
  logic                mode_q, mode_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   x_q, x_d, y_q, y_d, g_q, g_d;
  logic [DC_W-1:0]     dcnt_q, dcnt_d;
  logic [DATA_W-1:0]   gcd_o_q, gcd_o_d;
  logic [2*DATA_W-1:0] lcm_o_q, lcm_o_d;
  logic [TAG_W-1:0]    tag_o_q, tag_o_d;

  logic [DATA_W:0]     r_sh;
  logic [DATA_W-1:0]   r_sub;
  logic                r_ge;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    y_d     = y_q;
    g_d     = g_q;
    dcnt_d  = dcnt_q;
    gcd_o_d = gcd_o_q;
    lcm_o_d = lcm_o_q;
    tag_o_d = tag_o_q;
    // During DIV, x holds the partial remainder and y shifts dividend bits out / quotient bits in.
    r_sh  = {x_q, y_q[DATA_W-1]};
    r_ge  = r_sh[DATA_W] || (r_sh[DATA_W-1:0] >= g_q);
    r_sub = r_sh[DATA_W-1:0] - g_q;
    prod  = {{DATA_W{1'b0}}, y_q} * {{DATA_W{1'b0}}, b_q};

    unique case (state_q)
      S_IDLE: begin
        if (vld_in && rdy_q) begin
          a_d     = a_in;
          b_d     = b_in;
          mode_d  = mode_in;
          tag_d   = tag_in;
          x_d     = a_in;
          y_d     = b_in;
          state_d = S_GCD;
        end
      end
      S_GCD: begin
        // A zero operand is caught on the first GCD cycle so it still takes one edge.
        if (x_q == '0 || y_q == '0) begin
          gcd_o_d = x_q | y_q;
          lcm_o_d = '0;
          tag_o_d = tag_q;
          vld_d   = 1'b1;
          state_d = S_DONE;
        end else if (x_q == y_q) begin
          g_d = x_q;
          if (mode_q) begin
            x_d     = '0;
            y_d     = a_q;
            dcnt_d  = '0;
            state_d = S_DIV;
          end else begin
            gcd_o_d = x_q;
            lcm_o_d = '0;
            tag_o_d = tag_q;
            vld_d   = 1'b1;
            state_d = S_DONE;
          end
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      S_DIV: begin
        x_d    = r_ge ? r_sub : r_sh[DATA_W-1:0];
        y_d    = {y_q[DATA_W-2:0], r_ge};
        dcnt_d = dcnt_q + DC_W'(1);
        if (dcnt_q == DC_W'(DATA_W - 1)) state_d = S_MUL;
      end
      S_MUL: begin
        gcd_o_d = g_q;
        lcm_o_d = prod;
        tag_o_d = tag_q;
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rdy_out) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so ready stays low through reset and rises one edge after release.
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      mode_q  <= 1'b0;
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      g_q     <= '0;
      dcnt_q  <= '0;
      gcd_o_q <= '0;
      lcm_o_q <= '0;
      tag_o_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      g_q     <= g_d;
      dcnt_q  <= dcnt_d;
      gcd_o_q <= gcd_o_d;
      lcm_o_q <= lcm_o_d;
      tag_o_q <= tag_o_d;
    end
  end

  assign rdy_in  = rdy_q;
  assign vld_out = vld_q;
  assign gcd_out = gcd_o_q;
  assign lcm_out = lcm_o_q;
  assign tag_out = tag_o_q;

`ifdef GCD_LCM_CYC_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d, cnt_inc;

  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    if (state_q == S_IDLE) begin
      if (vld_in && rdy_q) cnt_d = '0;
    end else if (state_q != S_DONE) begin
      cnt_d = cnt_inc;
      if (state_d == S_DONE) cyc_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
    end
  end

  assign cyc_cnt_out = cyc_q;
`else
  // CNT_W only sizes the optional cycle counter.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_gcd_lcm_engine.sv
// Directed scoreboard bench for gcd_lcm_engine (DATA_W=8): expected results queued at issue,
// checked by an independent output monitor, including latency, stalls and mid-run reset.
module tb_gcd_lcm_engine;

  logic        clk;
  logic        rst;
  logic [7:0]  a_in, b_in;
  logic        mode_in;
  logic [3:0]  tag_in;
  logic        vld_in;
  logic        rdy_in;
  logic [7:0]  gcd_out;
  logic [15:0] lcm_out;
  logic [3:0]  tag_out;
  logic        vld_out;
  logic        rdy_out;
`ifdef GCD_LCM_CYC_CNT_EN
  logic [15:0] cyc_cnt_out;
`endif

  gcd_lcm_engine #(.DATA_W(8), .TAG_W(4), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_in    (a_in),
    .b_in    (b_in),
    .mode_in (mode_in),
    .tag_in  (tag_in),
    .vld_in  (vld_in),
    .rdy_in  (rdy_in),
    .gcd_out (gcd_out),
    .lcm_out (lcm_out),
    .tag_out (tag_out),
    .vld_out (vld_out),
    .rdy_out (rdy_out)
`ifdef GCD_LCM_CYC_CNT_EN
    ,
    .cyc_cnt_out (cyc_cnt_out)
`endif
  );

  typedef struct packed {
    logic [7:0]  g;
    logic [15:0] l;
    logic [3:0]  t;
    logic [15:0] n;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  exp_t cur;
  int   acc_cur;
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  logic prev_vld = 1'b0;
  logic prev_hs = 1'b0;
  logic rand_bp = 1'b0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      rdy_out = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic m,
                       input logic [3:0] t, output int acc);
    int w;
    w = 0;
    @(posedge clk);
    #1;
    a_in = a; b_in = b; mode_in = m; tag_in = t; vld_in = 1'b1;
    @(negedge clk);
    while (!rdy_in && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!rdy_in) begin
      chk("accept_timeout", 32'(rdy_in), 32'd1);
      vld_in = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = edge_cnt;
      vld_in = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m,
                      input logic [3:0] t, input logic [7:0] eg, input logic [15:0] el,
                      input logic [15:0] en);
    int acc;
    exp_t e;
    issue(a, b, m, t, acc);
    if (acc >= 0) begin
      e.g = eg; e.l = el; e.t = t; e.n = en;
      exp_q.push_back(e);
      acc_q.push_back(acc);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || vld_out || !rdy_in) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      if (prev_hs) begin
        chk("vld_drop_after_hs", 32'(vld_out), 32'd0);
        chk("rdy_in_after_hs", 32'(rdy_in), 32'd1);
      end
      if (vld_out) begin
        chk("rdy_in_low_while_vld", 32'(rdy_in), 32'd0);
        if (!prev_vld || prev_hs) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
            acc_cur = acc_q.pop_front();
            chk("latency", 32'(edge_cnt - acc_cur), 32'(cur.n));
          end
        end
        chk("gcd_out", 32'(gcd_out), 32'(cur.g));
        chk("lcm_out", 32'(lcm_out), 32'(cur.l));
        chk("tag_out", 32'(tag_out), 32'(cur.t));
`ifdef GCD_LCM_CYC_CNT_EN
        chk("cyc_cnt_out", 32'(cyc_cnt_out), 32'(cur.n));
`endif
      end
      prev_vld = vld_out;
      prev_hs  = vld_out && rdy_out;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int w;
    rst = 1'b1; vld_in = 1'b0; a_in = '0; b_in = '0; mode_in = 1'b0; tag_in = '0;
    rdy_out = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_rdy_in", 32'(rdy_in), 32'd0);
    chk("rst_vld_out", 32'(vld_out), 32'd0);
    chk("rst_gcd", 32'(gcd_out), 32'd0);
    chk("rst_lcm", 32'(lcm_out), 32'd0);
    chk("rst_tag", 32'(tag_out), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rdy_before_first_edge", 32'(rdy_in), 32'd0);
    @(posedge clk);
    #1;
    chk("rdy_after_first_edge", 32'(rdy_in), 32'd1);

    // 1: basic LCM request, S=6
    send(8'd6, 8'd7, 1'b1, 4'd3, 8'd1, 16'd42, 16'd16);
    wait_idle();

    // 2: backpressure with an ignored request during the stall
    rdy_out = 1'b0;
    send(8'd12, 8'd8, 1'b1, 4'd5, 8'd4, 16'd24, 16'd12);
    w = 0;
    @(negedge clk);
    while (!vld_out && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("bp_vld_seen", 32'(vld_out), 32'd1);
    @(posedge clk);
    #1;
    a_in = 8'd9; b_in = 8'd3; mode_in = 1'b1; tag_in = 4'd6; vld_in = 1'b1;
    @(negedge clk);
    chk("bp_rdy_in_low", 32'(rdy_in), 32'd0);
    @(posedge clk);
    #1 vld_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rdy_out = 1'b1;
    wait_idle();

    // 3: GCD-only and zero operands
    send(8'd15, 8'd20, 1'b0, 4'd1, 8'd5, 16'd0, 16'd4);
    send(8'd0, 8'd9, 1'b0, 4'd2, 8'd9, 16'd0, 16'd1);
    send(8'd0, 8'd0, 1'b1, 4'd4, 8'd0, 16'd0, 16'd1);
    send(8'd7, 8'd0, 1'b1, 4'd11, 8'd7, 16'd0, 16'd1);

    // 4: boundary values
    send(8'd255, 8'd254, 1'b1, 4'd12, 8'd1, 16'd64770, 16'd264);
    send(8'd255, 8'd255, 1'b1, 4'd13, 8'd255, 16'd255, 16'd10);
    wait_idle();

    // 5: reset in the middle of a long request
    issue(8'd255, 8'd254, 1'b1, 4'd9, acc);
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_gcd", 32'(gcd_out), 32'd0);
    chk("midrst_lcm", 32'(lcm_out), 32'd0);
    chk("midrst_tag", 32'(tag_out), 32'd0);
    chk("midrst_vld", 32'(vld_out), 32'd0);
    chk("midrst_rdy", 32'(rdy_in), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'd12, 8'd8, 1'b1, 4'd10, 8'd4, 16'd24, 16'd12);
    wait_idle();

    // 6: mixed vectors under random output stalls
    rand_bp = 1'b1;
    send(8'd21, 8'd6, 1'b1, 4'd7, 8'd3, 16'd42, 16'd14);
    send(8'd100, 8'd75, 1'b0, 4'd8, 8'd25, 16'd0, 16'd4);
    send(8'd13, 8'd13, 1'b0, 4'd14, 8'd13, 16'd0, 16'd1);
    send(8'd1, 8'd200, 1'b1, 4'd15, 8'd1, 16'd200, 16'd209);
    send(8'd24, 8'd36, 1'b1, 4'd0, 8'd12, 16'd72, 16'd12);
    wait_idle();
    rand_bp = 1'b0;
    #2 rdy_out = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
